// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode
//   Registered 16-bit instruction decoder. Splits an instruction word into
//   its opcode, register indices, shift amount, immediate and jump offset,
//   and classifies it as R-type, I-type, J-type or illegal. Outputs appear
//   one clock after a valid word is sampled. When no word is valid, the
//   field outputs keep their last decoded values.
//
//   Build option:
//     DECODE_FIELD_ZERO_EN - when defined, fields that do not belong to the
//                            decoded class are driven to 0, and an illegal
//                            opcode zeroes every field except opcode.
//                            When undefined, every field carries its raw
//                            bit slice of the instruction word.
//
//   Parameters:
//     ILLEGAL_OPCODE - opcode value reported as illegal (default 4'hF)
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   instr is valid this cycle
//     instr      in   [15:0] instruction word
//     out_valid  out  registered fields valid
//     opcode     out  [3:0] instr[15:12]
//     rd_index   out  [2:0] destination register index
//     rs_index   out  [2:0] source register index
//     rt_index   out  [2:0] second source register index
//     shamt      out  [2:0] shift amount
//     constant   out  [5:0] I-type immediate, unsigned
//     address    out  [8:0] J-type jump offset
//     instr_type out  [1:0] 0 R, 1 I, 2 J, 3 illegal
//     illegal    out  opcode equals ILLEGAL_OPCODE
// ---------------------------------------------------------------------------
module decode #(
    parameter logic [3:0] ILLEGAL_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic        out_valid,
    output logic [3:0]  opcode,
    output logic [2:0]  rd_index,
    output logic [2:0]  rs_index,
    output logic [2:0]  rt_index,
    output logic [2:0]  shamt,
    output logic [5:0]  constant,
    output logic [8:0]  address,
    output logic [1:0]  instr_type,
    output logic        illegal
);

    localparam logic [1:0] TYPE_R   = 2'd0;
    localparam logic [1:0] TYPE_I   = 2'd1;
    localparam logic [1:0] TYPE_J   = 2'd2;
    localparam logic [1:0] TYPE_BAD = 2'd3;

    logic [3:0] nxt_opcode;
    logic [2:0] nxt_rd;
    logic [2:0] nxt_rs;
    logic [2:0] nxt_rt;
    logic [2:0] nxt_shamt;
    logic [5:0] nxt_constant;
    logic [8:0] nxt_address;
    logic [1:0] nxt_type;
    logic       nxt_illegal;

    always_comb begin
        nxt_opcode   = instr[15:12];
        nxt_rd       = instr[11:9];
        nxt_rs       = instr[8:6];
        nxt_rt       = instr[5:3];
        nxt_shamt    = instr[2:0];
        nxt_constant = instr[5:0];
        nxt_address  = instr[11:3];
        nxt_illegal  = 1'b0;
        nxt_type     = TYPE_BAD;

        // The illegal compare takes priority so a non-default ILLEGAL_OPCODE
        // can mark any class's opcode as illegal. An opcode of 15 that is not
        // the illegal value belongs to no class and reports type 3.
        if (nxt_opcode == ILLEGAL_OPCODE) begin
            nxt_illegal = 1'b1;
            nxt_type    = TYPE_BAD;
        end else if (nxt_opcode < 4'd8) begin
            nxt_type = TYPE_R;
        end else if (nxt_opcode < 4'd12) begin
            nxt_type = TYPE_I;
        end else if (nxt_opcode < 4'd15) begin
            nxt_type = TYPE_J;
        end

`ifdef DECODE_FIELD_ZERO_EN
        case (nxt_type)
            TYPE_R: begin
                nxt_constant = '0;
                nxt_address  = '0;
            end
            TYPE_I: begin
                nxt_rt      = '0;
                nxt_shamt   = '0;
                nxt_address = '0;
            end
            TYPE_J: begin
                nxt_rd       = '0;
                nxt_rs       = '0;
                nxt_rt       = '0;
                nxt_shamt    = '0;
                nxt_constant = '0;
            end
            default: begin
                nxt_rd       = '0;
                nxt_rs       = '0;
                nxt_rt       = '0;
                nxt_shamt    = '0;
                nxt_constant = '0;
                nxt_address  = '0;
            end
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            opcode     <= '0;
            rd_index   <= '0;
            rs_index   <= '0;
            rt_index   <= '0;
            shamt      <= '0;
            constant   <= '0;
            address    <= '0;
            instr_type <= '0;
            illegal    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                opcode     <= nxt_opcode;
                rd_index   <= nxt_rd;
                rs_index   <= nxt_rs;
                rt_index   <= nxt_rt;
                shamt      <= nxt_shamt;
                constant   <= nxt_constant;
                address    <= nxt_address;
                instr_type <= nxt_type;
                illegal    <= nxt_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode
//   Self-checking bench for decode. A reference model computes the decoded
//   fields with plain arithmetic on the instruction word, and tracks the
//   one-cycle latency, hold-on-idle and reset behaviour. Honours
//   DECODE_FIELD_ZERO_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_decode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic        out_valid;
    logic [3:0]  opcode;
    logic [2:0]  rd_index;
    logic [2:0]  rs_index;
    logic [2:0]  rt_index;
    logic [2:0]  shamt;
    logic [5:0]  constant;
    logic [8:0]  address;
    logic [1:0]  instr_type;
    logic        illegal;

    int tests_run;
    int tests_failed;

    // Reference model state
    int e_valid, e_opc, e_rd, e_rs, e_rt, e_sh, e_cst, e_addr, e_type, e_ill;

    logic [34:0] act_vec;
    logic [34:0] exp_vec;

    decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .instr      (instr),
        .out_valid  (out_valid),
        .opcode     (opcode),
        .rd_index   (rd_index),
        .rs_index   (rs_index),
        .rt_index   (rt_index),
        .shamt      (shamt),
        .constant   (constant),
        .address    (address),
        .instr_type (instr_type),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_vec = {out_valid, opcode, rd_index, rs_index, rt_index, shamt,
                      constant, address, instr_type, illegal};
    assign exp_vec = {e_valid[0], 4'(e_opc), 3'(e_rd), 3'(e_rs), 3'(e_rt),
                      3'(e_sh), 6'(e_cst), 9'(e_addr), 2'(e_type), e_ill[0]};

    // Model of one clock edge with the currently applied inputs.
    task automatic model_edge();
        int w;
        w = int'(instr);
        if (rst_n === 1'b0) begin
            e_valid = 0; e_opc = 0; e_rd = 0; e_rs = 0; e_rt = 0;
            e_sh = 0; e_cst = 0; e_addr = 0; e_type = 0; e_ill = 0;
        end else if (in_valid === 1'b1) begin
            e_valid = 1;
            e_opc   = w / 4096;
            e_rd    = (w / 512) % 8;
            e_rs    = (w / 64) % 8;
            e_rt    = (w / 8) % 8;
            e_sh    = w % 8;
            e_cst   = w % 64;
            e_addr  = (w / 8) % 512;
            if (e_opc == 15)      begin e_type = 3; e_ill = 1; end
            else if (e_opc <= 7)  begin e_type = 0; e_ill = 0; end
            else if (e_opc <= 11) begin e_type = 1; e_ill = 0; end
            else                  begin e_type = 2; e_ill = 0; end
`ifdef DECODE_FIELD_ZERO_EN
            if (e_type == 0) begin e_cst = 0; e_addr = 0; end
            if (e_type == 1) begin e_rt = 0; e_sh = 0; e_addr = 0; end
            if (e_type == 2) begin e_rd = 0; e_rs = 0; e_rt = 0; e_sh = 0; e_cst = 0; end
            if (e_type == 3) begin e_rd = 0; e_rs = 0; e_rt = 0; e_sh = 0; e_cst = 0; e_addr = 0; end
`endif
        end else begin
            e_valid = 0;
        end
    endtask

    // Apply inputs, clock once, update model, settle away from the edge.
    task automatic step(input logic r, input logic v, input logic [15:0] w);
        rst_n    = r;
        in_valid = v;
        instr    = w;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 16'h8E48);
        tests_run++;
        if (act_vec !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_zero: got %h expected %h", act_vec, 35'd0);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vecs [5];
        vecs[0] = 16'h0E40; vecs[1] = 16'h1E41; vecs[2] = 16'h8E48;
        vecs[3] = 16'hC010; vecs[4] = 16'hF123;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, vecs[i]);
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL directed_model[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
            tests_run++;
            case (i)
                0: if ({out_valid, opcode, rd_index, rs_index, rt_index, shamt, instr_type} !==
                       {1'b1, 4'd0, 3'd7, 3'd1, 3'd0, 3'd0, 2'd0}) begin
                       tests_failed++;
                       $display("FAIL rtype_0E40: got op=%0d rd=%0d rs=%0d rt=%0d sh=%0d ty=%0d", opcode, rd_index, rs_index, rt_index, shamt, instr_type);
                   end
                1: if ({opcode, rd_index, rs_index, rt_index, shamt, instr_type} !==
                       {4'd1, 3'd7, 3'd1, 3'd0, 3'd1, 2'd0}) begin
                       tests_failed++;
                       $display("FAIL shift_1E41: got op=%0d rd=%0d rs=%0d rt=%0d sh=%0d ty=%0d", opcode, rd_index, rs_index, rt_index, shamt, instr_type);
                   end
                2: if ({opcode, rd_index, rs_index, constant, instr_type} !==
                       {4'd8, 3'd7, 3'd1, 6'd8, 2'd1}) begin
                       tests_failed++;
                       $display("FAIL itype_8E48: got op=%0d rd=%0d rs=%0d c=%0d ty=%0d", opcode, rd_index, rs_index, constant, instr_type);
                   end
                3: if ({opcode, address, instr_type, illegal} !== {4'd12, 9'd2, 2'd2, 1'b0}) begin
                       tests_failed++;
                       $display("FAIL jtype_C010: got op=%0d addr=%0d ty=%0d ill=%0d", opcode, address, instr_type, illegal);
                   end
                default: if ({opcode, instr_type, illegal} !== {4'd15, 2'd3, 1'b1}) begin
                       tests_failed++;
                       $display("FAIL illegal_F123: got op=%0d ty=%0d ill=%0d", opcode, instr_type, illegal);
                   end
            endcase
        end
    endtask

    task automatic test_hold();
        logic [33:0] prev_fields;
        step(1'b1, 1'b1, 16'h9ABC);
        prev_fields = act_vec[33:0];
        step(1'b1, 1'b0, 16'h5555);
        tests_run++;
        if (out_valid !== 1'b0 || act_vec[33:0] !== exp_vec[33:0]) begin
            tests_failed++;
            $display("FAIL hold_idle: got %h expected %h", act_vec, exp_vec);
        end
        tests_run++;
        if (act_vec[33:0] !== prev_fields) begin
            tests_failed++;
            $display("FAIL hold_unchanged: got %h expected %h", act_vec[33:0], prev_fields);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, {4'(i), 12'($urandom)});
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b1, 16'h3FFF);
        step(1'b0, 1'b1, 16'hBFFF);
        tests_run++;
        if (act_vec !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_midstream: got %h expected %h", act_vec, 35'd0);
        end
        step(1'b1, 1'b1, 16'hDFF8);
        tests_run++;
        if (act_vec !== exp_vec || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_after_reset: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        logic r, v;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 31) != 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 16'($urandom));
            tests_run++;
            if (act_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        e_valid = 0; e_opc = 0; e_rd = 0; e_rs = 0; e_rt = 0;
        e_sh = 0; e_cst = 0; e_addr = 0; e_type = 0; e_ill = 0;
        @(negedge clk);

        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter ILLEGAL_OPCODE, default 4'hF, is the opcode value reported as illegal.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  instr is valid this cycle.
REQ-005 instr  input  16  instruction word to decode.
REQ-006 out_valid  output  1  registered decode fields valid.
REQ-007 opcode  output  4  instr[15:12].
REQ-008 rd_index  output  3  destination register index.
REQ-009 rs_index  output  3  source register index.
REQ-010 rt_index  output  3  second source register index.
REQ-011 shamt  output  3  shift amount.
REQ-012 constant  output  6  I-type immediate, unsigned.
REQ-013 address  output  9  J-type jump offset.
REQ-014 instr_type  output  2  instruction class: 0 R, 1 I, 2 J, 3 illegal.
REQ-015 illegal  output  1  opcode equals ILLEGAL_OPCODE.

Function
REQ-016 All outputs SHALL be registered, with a latency of 1 cycle from in_valid/instr sampled to out_valid and fields.
REQ-017 When in_valid=1, out_valid SHALL be 1 next cycle; when in_valid=0, out_valid SHALL be 0 next cycle and all field outputs SHALL hold their previous values.
REQ-018 Opcodes 0-7 SHALL be R-type: rd=instr[11:9], rs=instr[8:6], rt=instr[5:3], shamt=instr[2:0].
REQ-019 Opcodes 8-11 SHALL be I-type: rd=instr[11:9], rs=instr[8:6], constant=instr[5:0].
REQ-020 Opcodes 12-14 SHALL be J-type: address=instr[11:3]; instr[2:0] are ignored.
REQ-021 An opcode equal to ILLEGAL_OPCODE SHALL set illegal=1 and instr_type=3, with opcode output still driven with the raw value.
REQ-022 The opcode output SHALL always equal instr[15:12], regardless of class.
REQ-023 Fields not defined for the decoded class SHALL follow REQ-033/REQ-034.
REQ-024 illegal SHALL be 0 for every opcode other than ILLEGAL_OPCODE.
REQ-025 Decode SHALL be purely per-word with no inter-instruction state; back-to-back valid words SHALL each produce one output cycle.

Reset
REQ-026 When rst_n=0 at a rising clk edge, out_valid, opcode, rd_index, rs_index, rt_index, shamt, constant, address, instr_type and illegal SHALL all become 0.
REQ-027 Reset SHALL override in_valid in the same cycle.
REQ-028 Reset asserted mid-stream SHALL discard the word sampled that cycle.
REQ-029 After reset, the first in_valid word SHALL decode normally.
REQ-030 There SHALL be no asynchronous path from rst_n to the outputs.

Configuration
REQ-031 The macro DECODE_FIELD_ZERO_EN SHALL select how unused fields are driven.
REQ-032 The macro is defined by default in the team build.
REQ-033 With DECODE_FIELD_ZERO_EN defined, fields not belonging to the decoded class SHALL be 0, and an illegal opcode SHALL zero every field except opcode:
- I-type: rt_index, shamt, address = 0.
- J-type: rd_index, rs_index, rt_index, shamt, constant = 0.
- R-type: constant, address = 0.
REQ-034 Without DECODE_FIELD_ZERO_EN, every field output SHALL carry its raw bit slice for all classes: rd[11:9], rs[8:6], rt[5:3], shamt[2:0], constant[5:0], address[11:3].

Verification
REQ-035 R-type: instr=16'h0E40 with in_valid=1 -> next cycle opcode=0, rd=7, rs=1, rt=0, shamt=0, instr_type=0, out_valid=1.
REQ-036 Shift: instr=16'h1E41 -> opcode=1, rd=7, rs=1, rt=0, shamt=1; with the macro defined, constant=0 and address=0.
REQ-037 I-type: instr=16'h8E48 -> opcode=8, rd=7, rs=1, constant=8, instr_type=1; with the macro defined, rt=0 and shamt=0.
REQ-038 J-type: instr=16'hC010 -> opcode=12, address=2, instr_type=2; with the macro defined, rd=0 and rs=0.
REQ-039 Illegal: instr=16'hF123 -> illegal=1, instr_type=3, opcode=15; with the macro defined, all other fields are 0.
REQ-040 Flow and reset:
- in_valid=0 for one cycle -> out_valid=0 and fields held.
- rst_n=0 during valid traffic -> all outputs 0 on the next edge.
